seven_segment_scanner: RTL and testbench
========================================

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 Parameter REFRESH_DIV, default 1000, clocks per digit slot (legal >= 2).
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port load  input  1  single-cycle strobe; captures value into the shadow register.
REQ-006 Port value  input  4*NUM_DIGITS  one nibble per digit; digit 0 = value[3:0] (least significant).
REQ-007 Port blank  input  1  level; when high, all digits dark.
REQ-008 Port seg  output  7  {a,b,c,d,e,f,g}, active-low (0 = segment lit), registered.
REQ-009 Port an  output  NUM_DIGITS  digit enables, active-low, one-hot-low or all-ones, registered.

Function
REQ-010 On load=1 the shadow register SHALL take value at that edge; load=0 SHALL hold the shadow.
REQ-011 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; on wrap the digit index SHALL advance by 1 modulo NUM_DIGITS (NUM_DIGITS-1 -> 0).
REQ-012 Each slot SHALL have two phases: GUARD (counter = 0) and SHOW (counter 1..REFRESH_DIV-1).
REQ-013 In GUARD, an SHALL be all ones and seg SHALL be 7'b1111111 (anti-ghosting).
REQ-014 In SHOW, an SHALL drive only bit [index] low and seg SHALL be the encoding of shadow nibble [index].
REQ-015 seg/an SHALL be registered: outputs reflect counter/index/shadow state with exactly 1 clock latency.
REQ-016 Encoding: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
REQ-017 A load coinciding with a slot wrap SHALL use the new shadow in the new slot's first SHOW cycle.
REQ-018 A load mid-SHOW SHALL change seg on the next cycle without resetting counter or index.
REQ-019 blank=1 SHALL force an all ones and seg 7'b1111111 (1-cycle latency); counter and index SHALL keep running; shadow SHALL still load.
REQ-020 NUM_DIGITS=1 SHALL hold index at 0; GUARD cycles still occur.

Reset
REQ-021 rst=1 SHALL clear counter, index and shadow to 0, set seg to 7'b1111111 and an to all ones on the next edge.
REQ-022 rst SHALL take priority over load and blank; a reset mid-slot SHALL restart at digit 0 GUARD after deassertion.

Configuration
REQ-023 Macro SEVEN_SEG_LEADING_ZERO_BLANK_EN: when defined, digit positions above the most significant nonzero shadow nibble SHALL show seg 7'b1111111 in SHOW (an still driven); digit 0 SHALL always display, so shadow 0 shows a single "0".
REQ-024 When undefined, all digits SHALL display their nibble including leading zeros; no suppression logic SHALL be synthesised.

Structure
REQ-025 Package seven_seg_pkg SHALL hold the 16 segment constants, SEG_OFF (7'b1111111) and the GUARD/SHOW state enum.
REQ-026 Sub-module hex_seven_segment_decoder (combinational 4-bit -> 7-bit per REQ-016) SHALL be instantiated once, fed by the index-selected nibble.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-027 Reset: rst high 2 cycles -> seg=1111111, an=1111; first slot after release digit 0 GUARD then SHOW with an=1110, seg=0000001.
REQ-028 Scan: load value=16'h12AF -> per 4-cycle slot, 1 GUARD cycle (an=1111) then an=1110 seg=0111000, an=1101 seg=0001000, an=1011 seg=0010010, an=0111 seg=1001111; wraps back to 1110.
REQ-029 Load at wrap: load 16'h0000 on the edge index goes 0->1 -> first SHOW of digit 1 shows seg=0000001.
REQ-030 Blank: blank high for 6 cycles mid-scan -> an=1111 throughout (1-cycle latency); on release, index equals the value it would have had without blank.
REQ-031 Leading zero (macro defined): load 16'h0050 -> digits 3,2 seg=1111111 with an active, digit 1 seg=0100100, digit 0 seg=0000001; undefined -> digits 3,2 seg=0000001.
REQ-032 Reset mid-operation: rst in SHOW of digit 2 -> next cycle seg=1111111, an=1111, shadow 0; scan resumes at digit 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low segment codes
// ({a,b,c,d,e,f,g}, 0 = lit) and the per-slot phase enum.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_2   = 7'b0010010;
  localparam logic [6:0] SEG_3   = 7'b0000110;
  localparam logic [6:0] SEG_4   = 7'b1001100;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_6   = 7'b0100000;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0000100;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b1100000;
  localparam logic [6:0] SEG_C   = 7'b0110001;
  localparam logic [6:0] SEG_D   = 7'b1000010;
  localparam logic [6:0] SEG_E   = 7'b0110000;
  localparam logic [6:0] SEG_F   = 7'b0111000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // GUARD is the dark first cycle of every digit slot; SHOW is the remainder.
  typedef enum logic {
    PH_GUARD = 1'b0,
    PH_SHOW  = 1'b1
  } phase_t;

endpackage

// File: rtl/hex_seven_segment_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_seven_segment_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed hex display driver with registered active-low seg/an.
// Optional macro SEVEN_SEG_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_next;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idx_next;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  phase_t                  r_phase;
  phase_t                  w_phase_next;
  logic [3:0]              w_nibble;
  logic [6:0]              w_dec_seg;
  logic                    w_digit_on;
  logic [6:0]              w_seg_next;
  logic [NUM_DIGITS-1:0]   w_an_next;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;

  // Phase FSM: the phase always mirrors whether the refresh counter sits at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= PH_GUARD;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_phase <= w_phase_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_cnt_next = r_cnt + CNT_W'(1);
    w_idx_next = r_idx;
    if (r_cnt == CNT_LAST) begin
      w_cnt_next = '0;
      w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end
    w_phase_next = (w_cnt_next == '0) ? PH_GUARD : PH_SHOW;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (load) begin
      r_shadow <= value;
    end
  end

  always_comb begin
    w_nibble  = r_shadow[3:0];
    w_an_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nibble     = r_shadow[4*i +: 4];
        w_an_next[i] = 1'b0;
      end
    end
  end

  hex_seven_segment_decoder u_decoder (
    .i_nibble (w_nibble),
    .o_seg    (w_dec_seg)
  );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // Highest nonzero digit position; digit 0 is always considered significant.
  logic [IDX_W-1:0] w_msd;

  always_comb begin
    w_msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (r_shadow[4*i +: 4] != 4'h0) w_msd = IDX_W'(i);
    end
  end

  assign w_digit_on = (r_idx <= w_msd);
`else
  assign w_digit_on = 1'b1;
`endif

  always_comb begin
    w_seg_next = w_digit_on ? w_dec_seg : SEG_OFF;
    if (blank || r_phase == PH_GUARD) begin
      w_seg_next = SEG_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || blank || r_phase == PH_GUARD) begin
      r_seg <= SEG_OFF;
      r_an  <= '1;
    end else begin
      r_seg <= w_seg_next;
      r_an  <= w_an_next;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner (NUM_DIGITS=4, REFRESH_DIV=4).
// Expected {seg,an} per cycle is queued by the driver and checked by a monitor.
module tb_seven_segment_scanner;

  localparam logic [6:0] E_OFF = 7'b1111111;
  localparam logic [6:0] E0 = 7'b0000001;
  localparam logic [6:0] E1 = 7'b1001111;
  localparam logic [6:0] E2 = 7'b0010010;
  localparam logic [6:0] E3 = 7'b0000110;
  localparam logic [6:0] E4 = 7'b1001100;
  localparam logic [6:0] E5 = 7'b0100100;
  localparam logic [6:0] E6 = 7'b0100000;
  localparam logic [6:0] E7 = 7'b0001111;
  localparam logic [6:0] E8 = 7'b0000000;
  localparam logic [6:0] E9 = 7'b0000100;
  localparam logic [6:0] EA = 7'b0001000;
  localparam logic [6:0] EB = 7'b1100000;
  localparam logic [6:0] EC = 7'b0110001;
  localparam logic [6:0] ED = 7'b1000010;
  localparam logic [6:0] EE = 7'b0110000;
  localparam logic [6:0] EF = 7'b0111000;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] EZ = E_OFF;  // leading-zero digit
`else
  localparam logic [6:0] EZ = E0;
`endif

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic        blank;
  logic [6:0]  seg;
  logic [3:0]  an;

  logic [10:0] exp_q[$];
  int          checks;
  int          errors;

  seven_segment_scanner #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .value (value),
    .blank (blank),
    .seg   (seg),
    .an    (an)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: outputs are sampled on the falling edge, one entry per clock.
  always @(negedge clk) begin
    logic [10:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({seg, an} !== e) begin
        errors++;
        $display("FAIL scan t=%0t: seg=%b an=%b expected seg=%b an=%b",
                 $time, seg, an, e[10:4], e[3:0]);
      end
    end
  end

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  // Queue the expected output for the coming edge, then let that edge happen.
  task automatic cyc(input logic [6:0] s, input logic [3:0] a);
    exp_q.push_back({s, a});
    @(posedge clk);
    #1;
  endtask

  // One 4-cycle digit slot. ld_cyc selects the cycle carrying a load (-1: none);
  // blk/rmask mark cycles with blank or rst high.
  task automatic slot(input int d, input logic [6:0] s_pre, input logic [6:0] s_post,
                      input int ld_cyc, input logic [15:0] ld_val,
                      input logic [3:0] blk, input logic [3:0] rmask);
    logic [6:0] es;
    logic [3:0] ea;
    for (int c = 0; c < 4; c++) begin
      rst   = rmask[c];
      blank = blk[c];
      load  = (c == ld_cyc);
      value = (c == ld_cyc) ? ld_val : 16'hDEAD;
      if (rmask[c] || blk[c] || c == 0) begin
        es = E_OFF;
        ea = 4'hF;
      end else begin
        es = (ld_cyc >= 0 && c > ld_cyc) ? s_post : s_pre;
        ea = an_of(d);
      end
      cyc(es, ea);
    end
    rst   = 1'b0;
    blank = 1'b0;
    load  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    load   = 1'b0;
    blank  = 1'b0;
    value  = 16'h0000;

    // Reset held two cycles, with a load that must be ignored
    cyc(E_OFF, 4'hF);
    load  = 1'b1;
    value = 16'h9999;
    cyc(E_OFF, 4'hF);
    load  = 1'b0;
    rst   = 1'b0;

    // Scan of cleared shadow
    slot(0, E0, E0, -1, 16'h0, 4'b0, 4'b0);
    slot(1, EZ, EZ, -1, 16'h0, 4'b0, 4'b0);
    slot(2, EZ, EZ, -1, 16'h0, 4'b0, 4'b0);
    slot(3, EZ, EZ, -1, 16'h0, 4'b0, 4'b0);

    // Load 12AF in the GUARD cycle of digit 0, then a full scan and wrap
    slot(0, E0, EF, 0, 16'h12AF, 4'b0, 4'b0);
    slot(1, EA, EA, -1, 16'h0, 4'b0, 4'b0);
    slot(2, E2, E2, -1, 16'h0, 4'b0, 4'b0);
    slot(3, E1, E1, -1, 16'h0, 4'b0, 4'b0);
    slot(0, EF, EF, -1, 16'h0, 4'b0, 4'b0);

    // Load mid-SHOW: digit 1 changes A -> b on the following cycle
    slot(1, EA, EB, 1, 16'h12BF, 4'b0, 4'b0);
    slot(2, E2, E2, -1, 16'h0, 4'b0, 4'b0);
    slot(3, E1, E1, -1, 16'h0, 4'b0, 4'b0);

    // Load 0000 on the wrap edge from digit 0 to digit 1
    slot(0, EF, EF, 3, 16'h0000, 4'b0, 4'b0);
    slot(1, EZ, EZ, -1, 16'h0, 4'b0, 4'b0);
    slot(2, EZ, EZ, -1, 16'h0, 4'b0, 4'b0);
    slot(3, EZ, EZ, -1, 16'h0, 4'b0, 4'b0);

    // Leading zeros with 0050
    slot(0, E0, E0, 0, 16'h0050, 4'b0, 4'b0);
    slot(1, E5, E5, -1, 16'h0, 4'b0, 4'b0);
    slot(2, EZ, EZ, -1, 16'h0, 4'b0, 4'b0);
    slot(3, EZ, EZ, -1, 16'h0, 4'b0, 4'b0);

    // Blank for 6 cycles with a load inside the blanked window
    slot(0, E0, E6, 0, 16'h3876, 4'b0, 4'b0);
    slot(1, E7, E7, -1, 16'h0, 4'b1100, 4'b0);
    slot(2, E8, E8, 1, 16'h3976, 4'b1111, 4'b0);
    slot(3, E3, E3, -1, 16'h0, 4'b0, 4'b0);
    slot(0, E6, E6, -1, 16'h0, 4'b0, 4'b0);
    slot(1, E7, E7, -1, 16'h0, 4'b0, 4'b0);

    // Reset during SHOW of digit 2, with a competing load
    slot(2, E9, E9, 2, 16'hFFFF, 4'b0, 4'b1100);
    slot(0, E0, E0, -1, 16'h0, 4'b0, 4'b0);
    slot(1, EZ, EZ, -1, 16'h0, 4'b0, 4'b0);
    slot(2, EZ, EZ, -1, 16'h0, 4'b0, 4'b0);
    slot(3, EZ, EZ, -1, 16'h0, 4'b0, 4'b0);

    // Remaining encodings
    slot(0, E0, E4, 0, 16'hEDC4, 4'b0, 4'b0);
    slot(1, EC, EC, -1, 16'h0, 4'b0, 4'b0);
    slot(2, ED, ED, -1, 16'h0, 4'b0, 4'b0);
    slot(3, EE, EE, -1, 16'h0, 4'b0, 4'b0);

    // Let the monitor drain the last entry
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
